aes_enc128_iter: RTL and testbench

//  Iterative AES-128 encryptor (FIPS-197). Computes one round per clock with on-the-fly key expansion.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/aes_enc_round.sv | 39 +++
 rtl/key_expansion.sv | 26 ++
 rtl/aes_enc128_iter.sv | 128 ++++++++++++
 tb/tb_aes_enc128_iter.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: forward S-box, GF(2^8) doubling, round count and FSM encoding.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x modulo 0x11b; the carry out of bit 7 folds back as 0x1b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_enc_round.sv
// Combinational AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on the last round), AddRoundKey.
module aes_enc_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] result
);

  logic [127:0] shifted;
  logic [127:0] mixed;

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte index is 4*col + row; row r of column c takes the byte from column (c + r) mod 4.
  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = sbox(state[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127 - 32*c -: 32] = mix_column(shifted[127 - 32*c -: 32]);
    end
  end

  assign result = (last ? shifted : mixed) ^ rk;

endmodule

// File: rtl/key_expansion.sv
// One AES-128 key-schedule step: next round key from the current one and the round constant word.
module key_expansion
  import aes_pkg::*;
(
  input  logic [127:0] key,
  input  logic [31:0]  rcon,
  output logic [127:0] next_key
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key;

  // SubWord(RotWord(w3)) ^ Rcon
  assign t = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ rcon;

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_enc128_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
module aes_enc128_iter
  import aes_pkg::*;
#(
  parameter bit CLEAR_ON_DONE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] out_data_q, out_data_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic         out_valid_q, out_valid_d;
  logic         init_q;

  logic [127:0] next_key;
  logic [127:0] round_out;
  logic         last_round;
  logic         rnd_legal;

  assign last_round = (rnd_q == LAST_RND);
  assign rnd_legal  = (rnd_q != 4'd0) && (rnd_q <= LAST_RND);

  key_expansion u_key_expansion (
    .key      (rk_q),
    .rcon     ({rcon_q, 24'h0}),
    .next_key (next_key)
  );

  aes_enc_round u_round (
    .state  (state_q),
    .rk     (next_key),
    .last   (last_round),
    .result (round_out)
  );

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // in_ready depends only on registered state (never on in_valid); out_data is held stable
  // for as long as out_valid is high and out_ready is low.
  assign in_ready  = init_q && (fsm_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (fsm_q == ROUND) || (fsm_q == DONE);

  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    rk_d       = rk_q;
    out_data_d = out_data_q;
    rnd_d      = rnd_q;
    rcon_d     = rcon_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d = in_data ^ in_key;
          rk_d    = in_key;
          rnd_d   = 4'd1;
          rcon_d  = 8'h01;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        if (rnd_legal) begin
          state_d = round_out;
          rk_d    = next_key;
          rcon_d  = xtime(rcon_q);
          rnd_d   = rnd_q + 4'd1;
          if (last_round) begin
            out_data_d = round_out;
            fsm_d      = DONE;
          end
        end else begin
          // Out-of-range round counts abandon the job rather than run on.
          fsm_d = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
          if (CLEAR_ON_DONE) begin
            state_d    = '0;
            rk_d       = '0;
            out_data_d = '0;
          end
        end
      end
      default: fsm_d = IDLE;
    endcase
    out_valid_d = (fsm_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= '0;
      rk_q        <= '0;
      out_data_q  <= '0;
      rnd_q       <= '0;
      rcon_q      <= '0;
      out_valid_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rk_q        <= rk_d;
      out_data_q  <= out_data_d;
      rnd_q       <= rnd_d;
      rcon_q      <= rcon_d;
      out_valid_q <= out_valid_d;
      init_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_enc128_iter.sv
// Bench for aes_enc128_iter: known-answer table, handshake corner sequences, random jobs vs. a byte-level AES model.
module tb_aes_enc128_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] in_key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic         in_ready_nc, out_valid_nc, busy_nc;
  logic [127:0] out_data_nc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]   ref_sbox [256];
  logic [7:0]   ref_rcon [11];
  logic [127:0] exp_q [$];

  typedef struct {
    string        name;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [3];

  aes_enc128_iter #(.CLEAR_ON_DONE(1'b1)) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_key (in_key),
    .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data), .busy (busy)
  );

  aes_enc128_iter #(.CLEAR_ON_DONE(1'b0)) dut_nc (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready_nc), .in_data (in_data), .in_key (in_key),
    .out_valid (out_valid_nc), .out_ready (out_ready), .out_data (out_data_nc), .busy (busy_nc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15 - n -: 8];
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    ref_rcon[0] = 8'h00;
    ref_rcon[1] = 8'h01;
    for (int i = 2; i <= 10; i++) ref_rcon[i] = gf_mul(ref_rcon[i-1], 8'h02);
  endtask

  function automatic logic [127:0] ref_encrypt(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] k [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      k[i] = key[127 - 8*i -: 8];
      s[i] = pt[127 - 8*i -: 8] ^ k[i];
    end
    for (int r = 1; r <= 10; r++) begin
      tmp[0] = ref_sbox[k[13]] ^ ref_rcon[r];
      tmp[1] = ref_sbox[k[14]];
      tmp[2] = ref_sbox[k[15]];
      tmp[3] = ref_sbox[k[12]];
      for (int j = 0; j < 4; j++) k[j] = k[j] ^ tmp[j];
      for (int j = 4; j < 16; j++) k[j] = k[j] ^ k[j-4];
      for (int i = 0; i < 16; i++) s[i] = ref_sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c + rw] = s[4*((c + rw) % 4) + rw];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++)
          s[4*c + j] = (r == 10) ? t[4*c + j] :
                       gf_mul(8'h02, t[4*c + j]) ^ gf_mul(8'h03, t[4*c + (j+1)%4]) ^
                       t[4*c + (j+2)%4] ^ t[4*c + (j+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_b({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_out_data"}, out_data, '0);
    check_b({tag, "_in_ready"}, in_ready, 1'b0);
    check_b({tag, "_busy"}, busy, 1'b0);
    check_b({tag, "_nc_out_valid"}, out_valid_nc, 1'b0);
    check({tag, "_nc_out_data"}, out_data_nc, '0);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge; returns just after the rising edge that accepted the job.
  task automatic drive_accept(input logic [127:0] key, input logic [127:0] pt);
    int n = 0;
    in_valid = 1'b1;
    in_key   = key;
    in_data  = pt;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required 1", n);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Counts rising edges from the accept edge until out_valid; returns at a falling edge.
  task automatic wait_done(input logic next_valid, input logic [127:0] next_key,
                           input logic [127:0] next_pt, output int lat);
    lat = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) begin
        in_valid = next_valid;
        in_key   = next_key;
        in_data  = next_pt;
      end
      if (lat >= 7 && lat <= 9)
        check_i($sformatf("rcon_round%0d", lat + 1), int'(dut.rcon_q), int'(ref_rcon[lat + 1]));
      if (out_valid) return;
      @(posedge clk);
      lat++;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: out_valid not seen after %0d edges, required 10", lat);
    lat = -1;
  endtask

  task automatic handshake_check(input logic [127:0] ct);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_b("hs_out_valid", out_valid, 1'b0);
    check_b("hs_in_ready", in_ready, 1'b1);
    check_b("hs_busy", busy, 1'b0);
    check("clr_out_data", out_data, '0);
    check("clr_state", dut.state_q, '0);
    check("clr_rk", dut.rk_q, '0);
    check("hold_out_data", out_data_nc, ct);
  endtask

  task automatic run_job(input string name, input logic [127:0] key, input logic [127:0] pt,
                         input logic [127:0] ct);
    int lat;
    drive_accept(key, pt);
    wait_done(1'b0, rand128(), rand128(), lat);
    check_i({name, "_latency"}, lat, 10);
    check({name, "_ct"}, out_data, ct);
    check_b({name, "_in_ready_done"}, in_ready, 1'b0);
    handshake_check(ct);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lat, t_a, t_b;
    logic [127:0] ka, pa, kb, pb, ca, cb, got;

    build_tables();
    vecs[0] = '{"fips_b",  128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[1] = '{"fips_c1", 128'h000102030405060708090a0b0c0d0e0f,
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{"zero",    128'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};

    // reset values
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_b("rst_release_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check_b("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_state", dut.state_q, '0);

    // known-answer table
    for (int i = 0; i < 3; i++) run_job(vecs[i].name, vecs[i].key, vecs[i].pt, vecs[i].ct);

    // backpressure: 20 stalled cycles in DONE with a competing in_valid
    ka = rand128(); pa = rand128(); ca = ref_encrypt(ka, pa);
    kb = rand128(); pb = rand128(); cb = ref_encrypt(kb, pb);
    drive_accept(ka, pa);
    wait_done(1'b1, kb, pb, lat);
    check_i("bp_latency", lat, 10);
    check("bp_ct_a", out_data, ca);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_hold_c%0d", i), out_data, ca);
      check_b($sformatf("bp_in_ready_c%0d", i), in_ready, 1'b0);
      check_b($sformatf("bp_out_valid_c%0d", i), out_valid, 1'b1);
    end
    handshake_check(ca);
    @(posedge clk);
    #1;
    check_b("bp_accept_busy", busy, 1'b1);
    check_b("bp_accept_in_ready", in_ready, 1'b0);
    wait_done(1'b0, rand128(), rand128(), lat);
    check_i("bp_latency_b", lat, 10);
    check("bp_ct_b", out_data, cb);
    handshake_check(cb);

    // back-to-back with out_ready tied high
    ka = vecs[0].key; pa = vecs[0].pt; ca = vecs[0].ct;
    kb = vecs[1].key; pb = vecs[1].pt; cb = vecs[1].ct;
    drive_accept(ka, pa);
    wait_done(1'b1, kb, pb, lat);
    t_a = cyc;
    check("b2b_ct_a", out_data, ca);
    out_ready = 1'b1;
    drive_accept(kb, pb);
    wait_done(1'b0, rand128(), rand128(), lat);
    t_b = cyc;
    check_i("b2b_spacing", t_b - t_a, 12);
    check("b2b_ct_b", out_data, cb);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_b("b2b_idle_out_valid", out_valid, 1'b0);
    check_b("b2b_idle_in_ready", in_ready, 1'b1);
    check("b2b_hold_out_data", out_data_nc, cb);

    // reset in the middle of round 5
    drive_accept(vecs[0].key, vecs[0].pt);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_i("mid_rnd", int'(dut.rnd_q), 5);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    check_reset_outputs("midrst_hold");
    rst_n = 1'b1;
    check_b("midrst_release_in_ready", in_ready, 1'b0);
    @(negedge clk);
    check_b("midrst_in_ready", in_ready, 1'b1);
    check_b("midrst_out_valid", out_valid, 1'b0);
    run_job("rerun_fips_b", vecs[0].key, vecs[0].pt, vecs[0].ct);

    // random jobs with random stalls and idle gaps
    for (int i = 0; i < 10; i++) begin
      ka = rand128();
      pa = rand128();
      exp_q.push_back(ref_encrypt(ka, pa));
      drive_accept(ka, pa);
      wait_done(1'b0, rand128(), rand128(), lat);
      check_i($sformatf("rnd%0d_latency", i), lat, 10);
      got = out_data;
      ca = exp_q.pop_front();
      check($sformatf("rnd%0d_ct", i), got, ca);
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) begin
        @(posedge clk);
        @(negedge clk);
        check($sformatf("rnd%0d_stall%0d", i, s), out_data, ca);
      end
      handshake_check(ca);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
